aline_acq_sequencer: RTL and testbench

Sequences A-line capture from the ADC sample stream into a ping-pong pair of A-line RAM banks in the `clk_system` domain. Each sweep-trigger rising edge starts a capture of exactly NSAMPLES samples into the free bank. The block then hands the bank to the readout side with a valid/ack handshake and counts A-lines per B-scan frame. It replaces the free-running address counters and `acq_busy` decode with an explicit, overflow-checked controller.

---
 rtl/aline_acq_pkg.sv | 20 ++
 rtl/aline_acq_sequencer_trig_sync.sv | 36 +++
 rtl/aline_acq_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_aline_acq_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aline_acq_pkg.sv
// ---------------------------------------------------------------------------
// aline_acq_pkg
// Shared definitions for the A-line acquisition sequencer: the controller
// state encoding and the default geometry (samples per A-line, A-lines per
// B-scan frame, RAM address width).
// ---------------------------------------------------------------------------
package aline_acq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ACQ     = 2'd2,
    ST_HANDOFF = 2'd3
  } acq_state_e;

  localparam int DEF_NSAMPLES = 1170;
  localparam int DEF_NALINES  = 512;
  localparam int DEF_AW       = 11;

endpackage

// File: rtl/aline_acq_sequencer_trig_sync.sv
// ---------------------------------------------------------------------------
// trig_sync_edge
// Two-flop synchronizer for the asynchronous sweep trigger followed by a
// rising-edge detector.
//   clk     in  system clock
//   srst    in  synchronous active-high reset
//   async_i in  asynchronous trigger level
//   rise_o  out high for one cycle after a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module trig_sync_edge (
  input  logic clk,
  input  logic srst,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // sync3 is only the previous value of sync2, used for edge detection.
  assign rise_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/aline_acq_sequencer.sv
// ---------------------------------------------------------------------------
// aline_acq_sequencer
// Captures exactly NSAMPLES ADC samples per sweep trigger into one of two
// ping-pong A-line RAM banks, hands full banks to the readout side with a
// valid/ack handshake and counts A-lines per B-scan frame.
//   clk_system    in  system clock
//   global_reset  in  synchronous active-high reset
//   enable        in  arm acquisition (level)
//   sweep_trigger in  asynchronous laser sweep trigger
//   sample_valid  in  ADC sample strobe
//   wr_en/wr_addr/wr_bank out  registered RAM write port
//   ready_valid/ready_bank out, ready_ack in  readout handshake
//   acq_busy      out high while capturing
//   aline_index   out index of last completed A-line in the frame
//   frame_done    out one-cycle pulse when a frame completes
//   overflow      out sticky: trigger dropped because target bank was full
//   early_trig    out sticky: trigger arrived while capturing/handing off
// ---------------------------------------------------------------------------
module aline_acq_sequencer
  import aline_acq_pkg::*;
#(
  parameter int NSAMPLES = DEF_NSAMPLES,
  parameter int NALINES  = DEF_NALINES,
  parameter int AW       = DEF_AW
) (
  input  logic          clk_system,
  input  logic          global_reset,
  input  logic          enable,
  input  logic          sweep_trigger,
  input  logic          sample_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_bank,
  output logic          ready_valid,
  output logic          ready_bank,
  input  logic          ready_ack,
  output logic          acq_busy,
  output logic [15:0]   aline_index,
  output logic          frame_done,
  output logic          overflow,
  output logic          early_trig
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NSAMPLES - 1);
  localparam logic [15:0]   LAST_LINE = 16'(NALINES - 1);

  acq_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wb_ptr_q, wb_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic [15:0]   line_cnt_q, line_cnt_d;
  logic [15:0]   aline_index_q, aline_index_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic          early_trig_q, early_trig_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_bank_q, wr_bank_d;
  logic          acq_busy_q;
  logic          trig_rise;

  trig_sync_edge u_trig_sync (
    .clk     (clk_system),
    .srst    (global_reset),
    .async_i (sweep_trigger),
    .rise_o  (trig_rise)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wb_ptr_d      = wb_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    bank_full_d   = bank_full_q;
    line_cnt_d    = line_cnt_q;
    aline_index_d = aline_index_q;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q;
    early_trig_d  = early_trig_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_bank_d     = wr_bank_q;

    // Readout side: an ack only counts while a full bank is presented.
    // The write side only ever sets the bank it owns, which is never the
    // bank being acknowledged, so both updates can land in one cycle.
    if (ready_ack && bank_full_q[rd_ptr_q]) begin
      bank_full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d              = ~rd_ptr_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d      = ST_ARMED;
          overflow_d   = 1'b0;
          early_trig_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (trig_rise) begin
          if (!bank_full_q[wb_ptr_q]) begin
            state_d = ST_ACQ;
            cnt_d   = '0;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      ST_ACQ: begin
        if (trig_rise) early_trig_d = 1'b1;
        if (sample_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_bank_d = wb_ptr_q;
          cnt_d     = cnt_q + AW'(1);
          if (cnt_q == LAST_ADDR) state_d = ST_HANDOFF;
        end
      end
      ST_HANDOFF: begin
        if (trig_rise) early_trig_d = 1'b1;
        bank_full_d[wb_ptr_q] = 1'b1;
        wb_ptr_d              = ~wb_ptr_q;
        // line_cnt_q is the index this A-line occupies in the frame.
        aline_index_d         = line_cnt_q;
        if (line_cnt_q == LAST_LINE) begin
          line_cnt_d   = '0;
          frame_done_d = 1'b1;
        end else begin
          line_cnt_d = line_cnt_q + 16'd1;
        end
        state_d = enable ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_system) begin
    if (global_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wb_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      bank_full_q   <= 2'b00;
      line_cnt_q    <= '0;
      aline_index_q <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      early_trig_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_bank_q     <= 1'b0;
      acq_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_ptr_q      <= wb_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      bank_full_q   <= bank_full_d;
      line_cnt_q    <= line_cnt_d;
      aline_index_q <= aline_index_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      early_trig_q  <= early_trig_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_bank_q     <= wr_bank_d;
      acq_busy_q    <= (state_d == ST_ACQ);
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_bank     = wr_bank_q;
  assign ready_valid = bank_full_q[rd_ptr_q];
  assign ready_bank  = rd_ptr_q;
  assign acq_busy    = acq_busy_q;
  assign aline_index = aline_index_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign early_trig  = early_trig_q;

endmodule

// File: tb/tb_aline_acq_sequencer.sv
module tb_aline_acq_sequencer;

  localparam int NS = 16;
  localparam int NL = 4;
  localparam int AW = 11;

  logic          clk_system = 1'b0;
  logic          global_reset, enable, sweep_trigger, sample_valid, ready_ack;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_bank, ready_valid, ready_bank, acq_busy;
  logic [15:0]   aline_index;
  logic          frame_done, overflow, early_trig;

  always #5 clk_system = ~clk_system;

  aline_acq_sequencer #(.NSAMPLES(NS), .NALINES(NL), .AW(AW)) dut (
    .clk_system    (clk_system),
    .global_reset  (global_reset),
    .enable        (enable),
    .sweep_trigger (sweep_trigger),
    .sample_valid  (sample_valid),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_bank       (wr_bank),
    .ready_valid   (ready_valid),
    .ready_bank    (ready_bank),
    .ready_ack     (ready_ack),
    .acq_busy      (acq_busy),
    .aline_index   (aline_index),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .early_trig    (early_trig)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_system);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          bank;
  } wr_t;

  wr_t exp_wr[$];        // writes the bench expects, in order
  bit  fullq[$];         // full banks awaiting readout, oldest first
  bit  m_wbank;          // bank the next accepted A-line goes to
  int  m_completed;      // A-lines completed since reset
  int  exp_fd_total = 0; // frame_done pulses expected over the whole run
  int  fd_seen      = 0;
  bit  m_ovf, m_early, m_armed;
  bit  sb_en = 1'b0;

  always @(negedge clk_system) begin
    wr_t e;
    if (frame_done) fd_seen++;
    if (sb_en && wr_en) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", {wr_bank, wr_addr}, 64'hFFFF);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_bank", wr_bank, e.bank);
      end
    end
  end

  task automatic do_reset();
    global_reset  = 1'b1;
    enable        = 1'b0;
    sweep_trigger = 1'b0;
    sample_valid  = 1'b0;
    ready_ack     = 1'b0;
    step();
    chk("reset_outputs", {wr_en, wr_addr, wr_bank, ready_valid, ready_bank, acq_busy,
                          aline_index, frame_done, overflow, early_trig}, 64'd0);
    step();
    global_reset = 1'b0;
    exp_wr.delete();
    fullq.delete();
    m_wbank = 1'b0; m_completed = 0;
    m_ovf = 1'b0; m_early = 1'b0; m_armed = 1'b0;
  endtask

  task automatic arm();
    enable = 1'b1;
    step();
    if (!m_armed) begin
      m_ovf = 1'b0; m_early = 1'b0; m_armed = 1'b1;
    end
  endtask

  task automatic disarm();
    enable = 1'b0;
    step();
    m_armed = 1'b0;
  endtask

  task automatic do_ack();
    chk("ack_ready_valid", ready_valid, fullq.size() > 0);
    if (fullq.size() > 0) chk("ack_ready_bank", ready_bank, fullq[0]);
    ready_ack = 1'b1;
    step();
    ready_ack = 1'b0;
    if (fullq.size() > 0) void'(fullq.pop_front());
    chk("post_ack_valid", ready_valid, fullq.size() > 0);
  endtask

  // One trigger followed by a stream of samples.
  // pattern: 0 continuous, 1 every other cycle, 2 random ~60%.
  // early_at / en_off_at: sample index at which a second trigger / enable=0
  // is applied (-1 = never). stop_at < NS leaves the capture unfinished.
  task automatic feed(input int pattern, input int early_at, input int en_off_at,
                      input int stop_at, input bit ack_end);
    int outcome;  // 0 capture, 1 dropped (bank full), 2 ignored (not armed)
    int n = 0;
    int guard = 0;
    int cyc = 0;
    bit v;
    bit tgt;
    outcome = !m_armed ? 2 : ((fullq.size() == 2) ? 1 : 0);
    tgt = m_wbank;
    sweep_trigger = 1'b1;
    step();
    sweep_trigger = 1'b0;
    if (outcome == 1) m_ovf = 1'b1;
    sample_valid = 1'($urandom % 2);
    step();
    chk("trig_sync_delay", acq_busy, 1'b0);
    sample_valid = 1'($urandom % 2);
    step();
    chk("trig_to_acq", acq_busy, outcome == 0);
    while (n < NS && n < stop_at && guard < 4000) begin
      guard++;
      case (pattern)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = ($urandom % 100) < 60;
      endcase
      cyc++;
      sample_valid  = v;
      sweep_trigger = v && (n == early_at);
      if (v && n == en_off_at) enable = 1'b0;
      if (v && outcome == 0) exp_wr.push_back('{addr: AW'(n), bank: tgt});
      if (v && outcome == 0 && n == early_at) m_early = 1'b1;
      if (v) n++;
      step();
    end
    if (guard >= 4000) chk("feed_timeout", guard, 0);
    sample_valid  = 1'b0;
    sweep_trigger = 1'b0;
    if (n < NS) return;
    if (outcome == 0) begin
      if (ack_end) ready_ack = 1'b1;
      step();
      ready_ack = 1'b0;
      if (ack_end && fullq.size() > 0) void'(fullq.pop_front());
      fullq.push_back(tgt);
      m_wbank = ~m_wbank;
      m_completed++;
      if (m_completed % NL == 0) exp_fd_total++;
      if (en_off_at >= 0) m_armed = 1'b0;
    end
    step();
    step();
    chk("aline_index", aline_index, (m_completed == 0) ? 0 : (m_completed - 1) % NL);
    chk("overflow", overflow, m_ovf);
    chk("early_trig", early_trig, m_early);
    chk("ready_valid", ready_valid, fullq.size() > 0);
    if (fullq.size() > 0) chk("ready_bank", ready_bank, fullq[0]);
    chk("acq_busy_idle", acq_busy, 1'b0);
    chk("frame_done_count", fd_seen, exp_fd_total);
  endtask

  // ---------------- cycle vector table ----------------
  typedef struct {
    bit en, trg, sv, ack;
    bit busy, we;
    int addr;
    bit rv;
  } vec_t;

  vec_t tbl[23];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 1, 0, 1, 0, 0, 0};
    for (int i = 0; i < NS; i++) tbl[4 + i] = '{1, 0, 1, 0, (i < NS - 1), 1, i, 0};
    tbl[20] = '{1, 0, 0, 0, 0, 0, 0, 1};
    tbl[21] = '{1, 0, 0, 1, 0, 0, 0, 0};
    tbl[22] = '{1, 0, 0, 1, 0, 0, 0, 0};

    do_reset();
    for (int r = 0; r < 23; r++) begin
      enable = tbl[r].en; sweep_trigger = tbl[r].trg;
      sample_valid = tbl[r].sv; ready_ack = tbl[r].ack;
      step();
      chk($sformatf("vec%0d_busy", r), acq_busy, tbl[r].busy);
      chk($sformatf("vec%0d_wr_en", r), wr_en, tbl[r].we);
      if (tbl[r].we) begin
        chk($sformatf("vec%0d_addr", r), wr_addr, tbl[r].addr);
        chk($sformatf("vec%0d_bank", r), wr_bank, 1'b0);
      end
      chk($sformatf("vec%0d_ready_valid", r), ready_valid, tbl[r].rv);
    end
    chk("vec_aline_index", aline_index, 0);
    sb_en = 1'b1;

    // Four A-lines with ack: banks alternate, frame_done on the fourth.
    do_reset();
    fd_seen = 0; exp_fd_total = 0;
    arm();
    for (int i = 0; i < 4; i++) begin
      feed(0, -1, -1, NS, 1'b0);
      do_ack();
    end

    // Three triggers without ack: third dropped, overflow sticky until re-arm.
    do_reset();
    arm();
    feed(0, -1, -1, NS, 1'b0);
    feed(0, -1, -1, NS, 1'b0);
    feed(0, -1, -1, NS, 1'b0);
    do_ack();
    feed(0, -1, -1, NS, 1'b0);
    disarm();
    arm();
    step();
    chk("overflow_cleared_on_rearm", overflow, 1'b0);

    // Trigger at sample 5 during capture.
    do_reset();
    arm();
    feed(0, 5, -1, NS, 1'b0);

    // Every-other-cycle samples, enable dropped at sample 8 -> IDLE.
    do_reset();
    arm();
    feed(1, -1, 8, NS, 1'b0);
    feed(0, -1, -1, NS, 1'b0);   // not armed: no capture expected
    arm();
    feed(0, -1, -1, NS, 1'b0);

    // Reset during capture at sample 10, then a fresh capture into bank 0.
    do_reset();
    arm();
    feed(0, -1, -1, 10, 1'b0);
    do_reset();
    arm();
    feed(0, -1, -1, NS, 1'b0);

    // HANDOFF set and ack of the other bank in the same cycle.
    do_reset();
    arm();
    feed(0, -1, -1, NS, 1'b0);
    feed(0, -1, -1, NS, 1'b1);
    chk("same_cycle_valid", ready_valid, 1'b1);
    chk("same_cycle_bank", ready_bank, 1'b1);

    // Randomized traffic against the model.
    do_reset();
    arm();
    for (int it = 0; it < 30; it++) begin
      int r;
      r = $urandom % 8;
      if (r < 3) do_ack();
      else if (r == 3) begin
        disarm();
        arm();
      end
      feed($urandom % 3, (($urandom % 4) == 0) ? int'(3 + $urandom % 8) : -1,
           -1, NS, (($urandom % 6) == 0));
    end
    step();
    chk("no_pending_writes", exp_wr.size(), 0);
    chk("frame_done_total", fd_seen, exp_fd_total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
